// File: rtl/fifo_pkg.sv
// Shared constants and types for the synchronous FIFO.
// Optional feature macro used by fifo_sync_param: FIFO_FWFT_EN.
package fifo_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int DEPTH_DEF     = 512;
  localparam int AF_THRESH_DEF = DEPTH_DEF - 4;
  localparam int AE_THRESH_DEF = 4;

  // Status flag bundle, registered as one unit so the flags always agree
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  localparam fifo_flags_t FLAGS_RST = '{
    full:         1'b0,
    empty:        1'b1,
    almost_full:  1'b0,
    almost_empty: 1'b1
  };

  // Derive the complete flag bundle from an occupancy value
  function automatic fifo_flags_t calc_flags(input int count, input int depth,
                                             input int af_thresh, input int ae_thresh);
    fifo_flags_t f;
    f.full         = (count == depth);
    f.empty        = (count == 32'sd0);
    f.almost_full  = (count >= af_thresh);
    f.almost_empty = (count <= ae_thresh);
    return f;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous
// read port. Contents are never reset.
module fifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 512
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port: store the incoming word at the write address
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_param.sv
// Parameterised single-clock FIFO with registered status flags, sticky
// overflow/underflow and selectable read mode.
// Define FIFO_FWFT_EN for first-word-fall-through; default is the standard
// mode where data_out is registered one cycle after an accepted read.
// DEPTH must be a power of two (>= 4) so pointers wrap naturally.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = AE_THRESH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   rd_en,
  input  logic                   err_clr,
  output logic [DATA_W-1:0]      data_out,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] data_count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  fifo_flags_t       flags_q, flags_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              wr_acc_s, rd_acc_s;
  logic [DATA_W-1:0] ram_rdata_s;

  // A full FIFO refuses writes and an empty one refuses reads; a read from a
  // full FIFO still frees a slot only on the following cycle.
  assign wr_acc_s = wr_en & ~flags_q.full;
  assign rd_acc_s = rd_en & ~flags_q.empty;

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_acc_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata_s)
  );

  // Next pointers, occupancy and the flags derived from the new occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_acc_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    flags_d = calc_flags(32'(count_d), DEPTH, AF_THRESH, AE_THRESH);
  end

  // Sticky error flags: a new offending request wins over a clear
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (wr_en && flags_q.full) begin
      overflow_d = 1'b1;
    end else if (err_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    if (rd_en && flags_q.empty) begin
      underflow_d = 1'b1;
    end else if (err_clr) begin
      underflow_d = 1'b0;
    end else begin
      underflow_d = underflow_q;
    end
  end

  // Control state register with asynchronous reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      flags_q     <= FLAGS_RST;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      flags_q     <= flags_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is shown directly; forced to zero while empty so reset reads 0
  assign data_out = flags_q.empty ? {DATA_W{1'b0}} : ram_rdata_s;
`else
  logic [DATA_W-1:0] data_out_q, data_out_d;

  // Capture the head word on an accepted read, otherwise hold
  always_comb begin
    data_out_d = data_out_q;
    if (rd_acc_s) begin
      data_out_d = ram_rdata_s;
    end else begin
      data_out_d = data_out_q;
    end
  end

  // Read data register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out_q <= {DATA_W{1'b0}};
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;
`endif

  assign full         = flags_q.full;
  assign empty        = flags_q.empty;
  assign almost_full  = flags_q.almost_full;
  assign almost_empty = flags_q.almost_empty;
  assign data_count   = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param against a queue-based model.
// Honours FIFO_FWFT_EN the same way the design does.
module tb_fifo_sync_param;

  localparam int DW  = 16;
  localparam int DEP = 512;
  localparam int AF  = DEP - 4;
  localparam int AE  = 4;
  localparam int CW  = $clog2(DEP) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          full, empty, almost_full, almost_empty;
  logic [CW-1:0] data_count;
  logic          overflow, underflow;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] q_m [$];
  logic          ovf_m = 1'b0;
  logic          udf_m = 1'b0;
  logic [DW-1:0] dout_m = '0;

  fifo_sync_param #(.DATA_W(DW), .DEPTH(DEP)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .err_clr      (err_clr),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .data_count   (data_count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_outputs();
    int sz;
    sz = q_m.size();
    check_val("data_count", 32'(data_count), 32'(sz));
    check_val("full", 32'(full), 32'(sz == DEP));
    check_val("empty", 32'(empty), 32'(sz == 0));
    check_val("almost_full", 32'(almost_full), 32'(sz >= AF));
    check_val("almost_empty", 32'(almost_empty), 32'(sz <= AE));
    check_val("overflow", 32'(overflow), 32'(ovf_m));
    check_val("underflow", 32'(underflow), 32'(udf_m));
`ifdef FIFO_FWFT_EN
    if (sz == 0) begin
      check_val("data_out_empty", 32'(data_out), 32'(dout_m));
    end else begin
      check_val("data_out_head", 32'(data_out), 32'(q_m[0]));
    end
`else
    check_val("data_out", 32'(data_out), 32'(dout_m));
`endif
  endtask

  // One clock: drive, update model from the rules, then check
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
    int  sz;
    logic wa, ra;
    wr_en = w; data_in = d; rd_en = r; err_clr = c;
    @(posedge clk);
    sz = q_m.size();
    wa = w && (sz != DEP);
    ra = r && (sz != 0);
    if (ra) dout_m = q_m.pop_front();
    if (wa) q_m.push_back(d);
`ifdef FIFO_FWFT_EN
    if (q_m.size() == 0) dout_m = '0;
`endif
    if (w && sz == DEP) ovf_m = 1'b1;
    else if (c) ovf_m = 1'b0;
    if (r && sz == 0) udf_m = 1'b1;
    else if (c) udf_m = 1'b0;
    #1;
    check_outputs();
  endtask

  task automatic model_reset();
    q_m.delete();
    ovf_m = 1'b0;
    udf_m = 1'b0;
    dout_m = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset, checked before any clock edge
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1'b1;

    // Fill with 1..512; flags tracked every cycle
    for (int i = 1; i <= DEP; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b0);
      if (i == AF) check_val("af_at_508", 32'(almost_full), 32'd1);
      if (i == AF - 1) check_val("af_below_508", 32'(almost_full), 32'd0);
    end
    check_val("full_after_512", 32'(full), 32'd1);
    check_val("count_512", 32'(data_count), 32'd512);

    // Write while full, then clear the sticky flag
    step(1'b1, 16'hDEAD, 1'b0, 1'b0);
    check_val("ovf_set", 32'(overflow), 32'd1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    check_val("ovf_clr", 32'(overflow), 32'd0);

    // Drain: data must come back as 1..512
    for (int i = 1; i <= DEP; i++) begin
      step(1'b0, 16'h0000, 1'b1, 1'b0);
`ifndef FIFO_FWFT_EN
      check_val("drain_order", 32'(data_out), 32'(i));
`endif
    end
    check_val("empty_after_drain", 32'(empty), 32'd1);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    check_val("udf_set", 32'(underflow), 32'd1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);

    // Offset pointers so the steady-state phase wraps them
    for (int i = 0; i < 200; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) step(1'b0, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 256; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      step(1'b1, DW'($urandom), 1'b1, 1'b0);
      check_val("steady_256", 32'(data_count), 32'd256);
    end

    // Drain, then simultaneous read/write on empty
    while (q_m.size() != 0) step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b1, 16'hBEEF, 1'b1, 1'b0);
    check_val("empty_rw_count", 32'(data_count), 32'd1);
    check_val("empty_rw_udf", 32'(underflow), 32'd1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);

    // Fill, then simultaneous read/write on full
    while (q_m.size() != DEP) step(1'b1, DW'($urandom), 1'b0, 1'b0);
    step(1'b1, 16'h1111, 1'b1, 1'b0);
    check_val("full_rw_count", 32'(data_count), 32'(DEP - 1));
    check_val("full_rw_ovf", 32'(overflow), 32'd1);

    // Randomised traffic, alternating bias to visit both ends
    for (int i = 0; i < 2000; i++) begin
      int wp;
      wp = ((i / 250) % 2 == 0) ? 25 : 75;
      step(($urandom_range(0, 99) < wp), DW'($urandom),
           ($urandom_range(0, 99) < (100 - wp)), ($urandom_range(0, 15) == 0));
    end

    // Bring occupancy to 300, then reset in the middle of a write
    while (q_m.size() < 300) step(1'b1, DW'($urandom), 1'b0, 1'b0);
    while (q_m.size() > 300) step(1'b0, 16'h0000, 1'b1, 1'b0);
    wr_en = 1'b1; rd_en = 1'b0; err_clr = 1'b0; data_in = 16'h7777;
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    wr_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b1;
    step(1'b1, 16'h1234, 1'b0, 1'b0);
    check_val("post_rst_count", 32'(data_count), 32'd1);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
`ifndef FIFO_FWFT_EN
    check_val("post_rst_data", 32'(data_out), 32'h1234);
`endif

    // Single word into empty, visible per mode, then popped
    step(1'b1, 16'h00A5, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
`ifdef FIFO_FWFT_EN
    check_val("fwft_a5", 32'(data_out), 32'h00A5);
`endif
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    check_val("a5_popped_empty", 32'(empty), 32'd1);
`ifndef FIFO_FWFT_EN
    check_val("std_a5", 32'(data_out), 32'h00A5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

Interface
REQ-001 Parameter DATA_W, default 8: data word width in bits.
REQ-002 Parameter DEPTH, default 512: number of entries; SHALL be a power of two, minimum 4.
REQ-003 Parameter AF_THRESH, default DEPTH-4: almost_full asserts when data_count >= AF_THRESH.
REQ-004 Parameter AE_THRESH, default 4: almost_empty asserts when data_count <= AE_THRESH.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 wr_en  in  1  write request.
REQ-008 data_in  in  DATA_W  write data.
REQ-009 rd_en  in  1  read request.
REQ-010 err_clr  in  1  clears sticky overflow/underflow flags.
REQ-011 data_out  out  DATA_W  read data.
REQ-012 full  out  1  data_count == DEPTH.
REQ-013 empty  out  1  data_count == 0.
REQ-014 almost_full  out  1  threshold flag per REQ-003.
REQ-015 almost_empty  out  1  threshold flag per REQ-004.
REQ-016 data_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-017 overflow  out  1  sticky: write attempted while full.
REQ-018 underflow  out  1  sticky: read attempted while empty.

Function
REQ-019 Write accepted iff wr_en && !full; data stored at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-020 Read accepted iff rd_en && !empty; rd_ptr increments modulo DEPTH.
REQ-021 Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 with no gap or duplication.
REQ-022 data_count: +1 on write-only, -1 on read-only, unchanged on simultaneous accepted read and write or neither.
REQ-023 Full with wr_en && rd_en: read accepted, write rejected, data_count -> DEPTH-1, overflow set.
REQ-024 Empty with wr_en && rd_en: write accepted, read rejected, data_count -> 1, underflow set.
REQ-025 full/empty/almost_full/almost_empty are registered, consistent with data_count in the same cycle.
REQ-026 overflow/underflow set on the cycle after the offending request; cleared by err_clr; set takes priority over err_clr in the same cycle.
REQ-027 Standard mode: data_out registered, valid one cycle after accepted read, holds value otherwise.
REQ-028 Data emerges in strict write order.

Reset
REQ-029 rst low: pointers, data_count, data_out, full, almost_full, overflow, underflow -> 0; empty, almost_empty -> 1; immediate, clock-independent.
REQ-030 Reset mid-operation discards all contents; memory array is not cleared.
REQ-031 First write accepted on the first rising edge after rst deasserts.

Configuration
REQ-032 Macro FIFO_FWFT_EN defined: first-word-fall-through; data_out presents head word whenever !empty, rd_en pops it, next word visible the following cycle; data_out is don't-care when empty.
REQ-033 FIFO_FWFT_EN undefined: standard mode per REQ-027; all other behaviour identical.

Structure
REQ-034 Package fifo_pkg holds default constants (DATA_W_DEF=8, DEPTH_DEF=512, AF/AE defaults) and a typedef for the flag bundle {full, empty, almost_full, almost_empty}.
REQ-035 Storage in sub-module fifo_ram: simple dual-port, one write port, one read port, parametrised DATA_W/DEPTH.

Verification
REQ-036 DEPTH=512, write 1..512 -> full=1 after 512th write, data_count=512, almost_full from count 508.
REQ-037 513th write while full -> rejected, data_count=512, overflow=1; err_clr pulse -> overflow=0.
REQ-038 Read 512 words -> data_out sequence 1..512 in order, empty=1, data_count=0; extra read -> underflow=1.
REQ-039 At count 256, wr_en && rd_en for 100 cycles -> data_count stays 256, order preserved across pointer wrap.
REQ-040 rst asserted at count 300 mid-write -> all outputs at REQ-029 values immediately; next write then read returns that word.
REQ-041 FIFO_FWFT_EN defined, single write of 0xA5 into empty -> data_out=0xA5 with rd_en low; rd_en pulse -> empty=1.
